// File: rtl/sram_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R) shared by the two masters and the SRAM slave.
// ID width is set per instance: master ID for M0/M1, extended slave ID for S.
// Width macros default to the AXI_define.svh values when not already defined.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS   4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS  8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS  4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

interface sram_rd_arbiter_if #(
    parameter int ID_BITS = `AXI_ID_BITS
);
    logic [ID_BITS-1:0]         arid;
    logic [`AXI_ADDR_BITS-1:0]  araddr;
    logic [`AXI_LEN_BITS-1:0]   arlen;
    logic [`AXI_SIZE_BITS-1:0]  arsize;
    logic [1:0]                 arburst;
    logic                       arvalid;
    logic                       arready;
    logic [ID_BITS-1:0]         rid;
    logic [`AXI_DATA_BITS-1:0]  rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    // Side that issues read requests and consumes read data
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Side that accepts read requests and returns read data
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/sram_rd_arbiter.sv
// Two-master to one-SRAM-slave AXI read arbiter, one transaction outstanding.
// IDLE forwards the winning request combinationally, ADDR locks the grant until
// the slave accepts, DATA routes the burst back to the locked master.
// Optional build macro ARB_FIXED_PRIO_EN: M0 always wins a tie (no RR pointer).

`ifndef AXI_ID_BITS
`define AXI_ID_BITS   4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS  8
`endif

module sram_rd_arbiter (
    input  logic              clk,
    input  logic              rst,
    sram_rd_arbiter_if.slave  m0_bus,
    sram_rd_arbiter_if.slave  m1_bus,
    sram_rd_arbiter_if.master s_bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic [3:0]  r_beat_cnt;
    logic        w_pick;
    logic        w_grant;
    logic        w_in_data;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_burst_end;
    logic        w_id_err;

`ifndef ARB_FIXED_PRIO_EN
    logic        r_last_grant;
`endif

    // Choose a winner among the masters requesting this cycle
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        w_pick = !m0_bus.arvalid && m1_bus.arvalid;
`else
        if (m0_bus.arvalid && m1_bus.arvalid)
            w_pick = ~r_last_grant;
        else
            w_pick = m1_bus.arvalid;
`endif
    end

    // Live pick while IDLE, locked grant once the request is on the bus
    assign w_grant   = (r_state == ST_IDLE) ? w_pick : r_grant;
    assign w_in_data = (r_state == ST_DATA);
    assign w_ar_hs   = s_bus.arvalid && s_bus.arready;
    assign w_r_hs    = s_bus.rvalid && s_bus.rready;
    // A 16th beat is the protocol maximum, so it ends the burst even without RLAST
    assign w_burst_end = w_r_hs && (s_bus.rlast || (r_beat_cnt == 4'hF));
    assign w_id_err  = (s_bus.rid[`AXI_IDS_BITS-1:`AXI_ID_BITS] != 4'(r_grant));

    // Address channel: forward the granted master's request to the slave
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        s_bus.arvalid  = 1'b0;
        m0_bus.arready = 1'b0;
        m1_bus.arready = 1'b0;
        if (r_state == ST_IDLE)
            s_bus.arvalid = m0_bus.arvalid || m1_bus.arvalid;
        else if (r_state == ST_ADDR)
            s_bus.arvalid = 1'b1;
        m0_bus.arready = s_bus.arvalid && !w_grant && s_bus.arready;
        m1_bus.arready = s_bus.arvalid &&  w_grant && s_bus.arready;

        if (w_grant) begin
            s_bus.arid    = {4'(1'b1), m1_bus.arid};
            s_bus.araddr  = m1_bus.araddr;
            s_bus.arlen   = m1_bus.arlen;
            s_bus.arsize  = m1_bus.arsize;
            s_bus.arburst = m1_bus.arburst;
        end else begin
            s_bus.arid    = {4'(1'b0), m0_bus.arid};
            s_bus.araddr  = m0_bus.araddr;
            s_bus.arlen   = m0_bus.arlen;
            s_bus.arsize  = m0_bus.arsize;
            s_bus.arburst = m0_bus.arburst;
        end
    end

    // Read data channel: route slave beats to the locked master only in DATA
    always_comb begin
        m0_bus.rvalid = w_in_data && !r_grant && s_bus.rvalid;
        m1_bus.rvalid = w_in_data &&  r_grant && s_bus.rvalid;
        m0_bus.rid    = s_bus.rid[`AXI_ID_BITS-1:0];
        m1_bus.rid    = s_bus.rid[`AXI_ID_BITS-1:0];
        m0_bus.rdata  = s_bus.rdata;
        m1_bus.rdata  = s_bus.rdata;
        m0_bus.rlast  = s_bus.rlast;
        m1_bus.rlast  = s_bus.rlast;
        // A beat tagged for the other master is still delivered, but flagged SLVERR
        m0_bus.rresp  = (s_bus.rvalid && w_id_err) ? 2'b10 : s_bus.rresp;
        m1_bus.rresp  = (s_bus.rvalid && w_id_err) ? 2'b10 : s_bus.rresp;
        s_bus.rready  = w_in_data && (r_grant ? m1_bus.rready : m0_bus.rready);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ar_hs)
                    w_state_nxt = ST_DATA;
                else if (s_bus.arvalid)
                    w_state_nxt = ST_ADDR;
            end
            ST_ADDR: if (w_ar_hs)     w_state_nxt = ST_DATA;
            ST_DATA: if (w_burst_end) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Lock the grant when a request leaves IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_grant <= 1'b0;
        else if ((r_state == ST_IDLE) && s_bus.arvalid)
            r_grant <= w_pick;
    end

    // Count accepted beats of the current burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_beat_cnt <= 4'd0;
        else if (w_ar_hs)
            r_beat_cnt <= 4'd0;
        else if (w_r_hs)
            r_beat_cnt <= r_beat_cnt + 4'd1;
    end

`ifndef ARB_FIXED_PRIO_EN
    // Remember the master served last; reset value lets M0 win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_grant <= 1'b1;
        else if (w_burst_end)
            r_last_grant <= r_grant;
    end
`endif

endmodule
